// File: rtl/ex_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_dmem_arbiter_pkg
// Brief    : Shared encodings for the EX data-SRAM arbiter: FSM states,
//            one-hot grant tags and the stall-request levels.
// Revision : 1.0 - initial release
// ============================================================================
package ex_dmem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    EXARB_IDLE   = 1'b0,
    EXARB_SECOND = 1'b1
  } exarb_state_e;

  // One-hot owner of the current SRAM access
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S1   = 2'b01;
  localparam logic [1:0] GRANT_S2   = 2'b10;

  // Stall request levels toward CTRL
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ex_dmem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with increment enable. Holds at all-ones
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled events, sticking at the maximum value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ex_dmem_arbiter
// Brief    : Shares the single data-SRAM port between the two EX issue slots.
//            A lone request passes straight through; a dual request issues
//            slot 1 first, parks slot 2 in a pending register and issues it
//            one cycle later while the pipeline is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module ex_dmem_arbiter
  import ex_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              s1_en,
  input  logic [3:0]        s1_wen,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic              s2_en,
  input  logic [3:0]        s2_wen,
  input  logic [ADDR_W-1:0] s2_addr,
  input  logic [DATA_W-1:0] s2_wdata,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  output logic [1:0]        grant,
  output logic              stallreq_for_ex,
  output logic              pending,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int PEND_W = 4 + ADDR_W + DATA_W;

  exarb_state_e      state;
  logic [PEND_W-1:0] pend_q;     // captured {wen, addr, wdata} of slot 2
  logic              pending_q;
  logic              dual_req;
  logic              capture;

  assign dual_req = s1_en & s2_en;
  // A conflict is only taken when nothing blocks the slot-1 access this cycle
  assign capture  = ~flush & ~hold & dual_req & (state == EXARB_IDLE);
  assign pending  = pending_q;

  // Select which request drives the SRAM port this cycle
  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    grant           = GRANT_NONE;
    stallreq_for_ex = NO_STOP;
    if (!flush) begin
      if (state == EXARB_SECOND) begin
        if (hold) begin
          // Keep the pipeline frozen until the parked access can go out
          stallreq_for_ex = STOP;
        end else begin
          data_sram_en = 1'b1;
          {data_sram_wen, data_sram_addr, data_sram_wdata} = pend_q;
          grant        = GRANT_S2;
        end
      end else if (!hold) begin
        if (s1_en) begin
          data_sram_en    = 1'b1;
          data_sram_wen   = s1_wen;
          data_sram_addr  = s1_addr;
          data_sram_wdata = s1_wdata;
          grant           = GRANT_S1;
          stallreq_for_ex = s2_en ? STOP : NO_STOP;
        end else if (s2_en) begin
          data_sram_en    = 1'b1;
          data_sram_wen   = s2_wen;
          data_sram_addr  = s2_addr;
          data_sram_wdata = s2_wdata;
          grant           = GRANT_S2;
        end
      end
    end
  end

  // Arbiter FSM: park slot 2 on a conflict, release it once hold drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EXARB_IDLE;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else if (flush) begin
      state     <= EXARB_IDLE;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      case (state)
        EXARB_IDLE: begin
          if (capture) begin
            state     <= EXARB_SECOND;
            pend_q    <= {s2_wen, s2_addr, s2_wdata};
            pending_q <= 1'b1;
          end
        end
        EXARB_SECOND: begin
          if (!hold) begin
            state     <= EXARB_IDLE;
            pend_q    <= '0;
            pending_q <= 1'b0;
          end
        end
        default: begin
          state     <= EXARB_IDLE;
          pend_q    <= '0;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (capture),
    .count (conflict_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_ex_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_dmem_arbiter
// Brief    : Self-checking bench for ex_dmem_arbiter: vector table, directed
//            multi-cycle sequences and randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, hold, s1_en, s2_en;
  logic [3:0]    s1_wen, s2_wen;
  logic [AW-1:0] s1_addr, s2_addr;
  logic [DW-1:0] s1_wdata, s2_wdata;
  logic          data_sram_en;
  logic [3:0]    data_sram_wen;
  logic [AW-1:0] data_sram_addr;
  logic [DW-1:0] data_sram_wdata;
  logic [1:0]    grant;
  logic          stallreq_for_ex;
  logic          pending;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  ex_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .s1_en(s1_en), .s1_wen(s1_wen), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s2_en(s2_en), .s2_wen(s2_wen), .s2_addr(s2_addr), .s2_wdata(s2_wdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .grant(grant), .stallreq_for_ex(stallreq_for_ex), .pending(pending),
    .conflict_cnt(conflict_cnt)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  // Reference model: queue of parked slot-2 accesses plus a saturating count
  acc_t        pq[$];
  int          m_cnt;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_load;

  typedef struct {
    logic        f, h, e1, e2;
    logic [3:0]  w1, w2;
    logic [31:0] a1, a2, d1, d2;
    logic [72:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [72:0] pack(logic en, logic [3:0] w, logic [31:0] a,
                                       logic [31:0] d, logic [1:0] g, logic st, logic p);
    return {en, w, a, d, g, st, p};
  endfunction

  function automatic logic [72:0] actual();
    return pack(data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                grant, stallreq_for_ex, pending);
  endfunction

  task automatic check_vec(string name, logic [72:0] exp);
    checks++;
    if (actual() !== exp) begin
      failures++;
      $display("FAIL %s: got en/wen/addr/wdata/grant/stall/pend=%h want %h", name, actual(), exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic set_in(logic f, logic h, logic e1, logic e2, logic [3:0] w1, logic [3:0] w2,
                        logic [31:0] a1, logic [31:0] a2, logic [31:0] d1, logic [31:0] d2);
    flush = f; hold = h; s1_en = e1; s2_en = e2; s1_wen = w1; s2_wen = w2;
    s1_addr = a1; s2_addr = a2; s1_wdata = d1; s2_wdata = d2;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Expected outputs from the arbitration rules and the parked-access queue
  function automatic logic [72:0] model_out();
    acc_t       a;
    logic       en;
    logic [1:0] g;
    logic       st;
    en = 1'b0; a = '0; g = 2'b00; st = 1'b0;
    if (!flush) begin
      if (pq.size() != 0) begin
        if (hold) st = 1'b1;
        else begin en = 1'b1; a = pq[0]; g = 2'b10; end
      end else if (!hold) begin
        if (s1_en) begin
          en = 1'b1; a = {s1_wen, s1_addr, s1_wdata}; g = 2'b01; st = s2_en;
        end else if (s2_en) begin
          en = 1'b1; a = {s2_wen, s2_addr, s2_wdata}; g = 2'b10;
        end
      end
    end
    return pack(en, a.wen, a.addr, a.wdata, g, st, pq.size() != 0);
  endfunction

  // Record the observed access into the memory model, advance a clock, update the model
  task automatic tick();
    logic [31:0] old;
    if (data_sram_en) begin
      old = mem.exists(data_sram_addr) ? mem[data_sram_addr] : 32'h0;
      if (data_sram_wen == 4'h0) last_load = old;
      else begin
        for (int b = 0; b < 4; b++)
          if (data_sram_wen[b]) old[8*b +: 8] = data_sram_wdata[8*b +: 8];
        mem[data_sram_addr] = old;
      end
    end
    @(posedge clk);
    #1;
    if (flush) pq.delete();
    else if (pq.size() != 0) begin
      if (!hold) void'(pq.pop_front());
    end else if (!hold && s1_en && s2_en) begin
      pq.push_back({s2_wen, s2_addr, s2_wdata});
      if (m_cnt < 15) m_cnt++;
    end
  endtask

  task automatic cyc(string name, logic [72:0] exp);
    #2;
    check_vec(name, exp);
    tick();
  endtask

  // Asynchronous reset, checked before any clock edge, released at a falling edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    pq.delete();
    m_cnt = 0;
    check_val("reset_cnt", 32'(conflict_cnt), 32'h0);
    check_val("reset_pending", 32'(pending), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(string n, logic f, logic h, logic e1, logic e2,
                              logic [3:0] w1, logic [3:0] w2, logic [31:0] a1, logic [31:0] a2,
                              logic [31:0] d1, logic [31:0] d2, logic [72:0] exp);
    vec_t v;
    v.name = n; v.f = f; v.h = h; v.e1 = e1; v.e2 = e2; v.w1 = w1; v.w2 = w2;
    v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2; v.exp = exp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_in();
    m_cnt = 0;
    last_load = 32'h0;

    tbl.push_back(mk("single_s2", 0,0,0,1, 4'h0,4'hF, 32'h0,32'h2004, 32'h0,32'hDEADBEEF,
                     pack(1,4'hF,32'h2004,32'hDEADBEEF,2'b10,0,0)));
    tbl.push_back(mk("dual_s1", 0,0,1,1, 4'hF,4'h0, 32'h3000,32'h3000, 32'h11,32'h0,
                     pack(1,4'hF,32'h3000,32'h11,2'b01,1,0)));
    tbl.push_back(mk("dual_s2", 0,0,1,1, 4'h3,4'h0, 32'hBAD0,32'hBAD4, 32'hBADBAD,32'h77,
                     pack(1,4'h0,32'h3000,32'h0,2'b10,0,1)));
    tbl.push_back(mk("hold_idle", 0,1,1,0, 4'h0,4'h0, 32'h80,32'h0, 32'h0,32'h0,
                     pack(0,4'h0,32'h0,32'h0,2'b00,0,0)));
    tbl.push_back(mk("no_req", 0,0,0,0, 4'h0,4'h0, 32'h0,32'h0, 32'h0,32'h0,
                     pack(0,4'h0,32'h0,32'h0,2'b00,0,0)));
    tbl.push_back(mk("single_s1", 0,0,1,0, 4'h3,4'h0, 32'h40,32'h0, 32'h55,32'h0,
                     pack(1,4'h3,32'h40,32'h55,2'b01,0,0)));
    tbl.push_back(mk("flush_dual", 1,0,1,1, 4'hF,4'hF, 32'h44,32'h48, 32'h1,32'h2,
                     pack(0,4'h0,32'h0,32'h0,2'b00,0,0)));
    tbl.push_back(mk("after_flush", 0,0,0,0, 4'h0,4'h0, 32'h0,32'h0, 32'h0,32'h0,
                     pack(0,4'h0,32'h0,32'h0,2'b00,0,0)));

    // Reset with a slot-1 request present, then zero-latency pass-through
    set_in(0, 0, 1, 0, 4'h0, 4'h0, 32'h1000, 32'h0, 32'h0, 32'h0);
    do_reset();
    cyc("reset_first", pack(1,4'h0,32'h1000,32'h0,2'b01,0,0));

    foreach (tbl[i]) begin
      set_in(tbl[i].f, tbl[i].h, tbl[i].e1, tbl[i].e2, tbl[i].w1, tbl[i].w2,
             tbl[i].a1, tbl[i].a2, tbl[i].d1, tbl[i].d2);
      cyc(tbl[i].name, tbl[i].exp);
    end
    check_val("load_after_store", last_load, 32'h11);
    check_val("cnt_after_dual", 32'(conflict_cnt), 32'h1);

    // Hold while slot 2 is parked
    set_in(0, 0, 1, 1, 4'hF, 4'h0, 32'h500, 32'h504, 32'hA, 32'h0);
    cyc("hold_dual_s1", pack(1,4'hF,32'h500,32'hA,2'b01,1,0));
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 1, 4'h5, 4'h5, 32'h9990, 32'h9994, 32'h9, 32'h9);
      cyc("hold_second", pack(0,4'h0,32'h0,32'h0,2'b00,1,1));
    end
    idle_in();
    cyc("hold_release", pack(1,4'h0,32'h504,32'h0,2'b10,0,1));
    cyc("hold_after", pack(0,4'h0,32'h0,32'h0,2'b00,0,0));
    check_val("cnt_after_hold", 32'(conflict_cnt), 32'h2);

    // Flush while slot 2 is parked: the parked access must never appear
    idle_in();
    do_reset();
    set_in(0, 0, 1, 1, 4'hF, 4'h0, 32'h600, 32'h604, 32'hB, 32'h0);
    cyc("flush_dual_s1", pack(1,4'hF,32'h600,32'hB,2'b01,1,0));
    set_in(1, 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc("flush_second", pack(0,4'h0,32'h0,32'h0,2'b00,0,1));
    idle_in();
    cyc("flush_after1", pack(0,4'h0,32'h0,32'h0,2'b00,0,0));
    cyc("flush_after2", pack(0,4'h0,32'h0,32'h0,2'b00,0,0));
    check_val("cnt_after_flush", 32'(conflict_cnt), 32'h1);

    // Reset while slot 2 is parked
    set_in(0, 0, 1, 1, 4'h0, 4'hF, 32'h700, 32'h704, 32'h0, 32'hC);
    cyc("rst_dual_s1", pack(1,4'h0,32'h700,32'h0,2'b01,1,0));
    idle_in();
    do_reset();
    cyc("rst_after", pack(0,4'h0,32'h0,32'h0,2'b00,0,0));

    // Saturation of the 4-bit conflict counter
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 1, 1, 4'h0, 4'h0, 32'h800, 32'h804, 32'h0, 32'h0);
      #2; tick();
      idle_in();
      #2; tick();
      if (i == 14) check_val("cnt_at_15", 32'(conflict_cnt), 32'hF);
    end
    check_val("cnt_saturated", 32'(conflict_cnt), 32'hF);

    // Randomized traffic against the reference model
    idle_in();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(15) == 0, $urandom_range(3) == 0,
             $urandom_range(1) == 1, $urandom_range(1) == 1,
             ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0,
             ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0,
             {$urandom_range(255), 2'b00}, {$urandom_range(255), 2'b00},
             $urandom, $urandom);
      #2;
      check_vec("rand_out", model_out());
      check_val("rand_cnt", 32'(conflict_cnt), 32'(m_cnt));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
